// File: rtl/hedios_rx_deframer.sv
// Receive deframer: assembles 5-byte command/data frames from a byte stream
// into a small packet FIFO, with overflow tracking and a partial-frame timeout.
module hedios_rx_deframer #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    input  logic        rx_pop_packet,
    output logic [7:0]  rx_command,
    output logic [31:0] rx_data,
    output logic        rx_empty,
    output logic        rx_full,
    output logic        rx_lost_data,
    output logic        frame_timeout
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ToW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [0:0] {S_CMD, S_DATA} state_e;

    state_e          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [31:0]     data_q, data_d;
    logic [ToW-1:0]  to_q, to_d;
    logic            timeout_q, timeout_d;
    logic            frame_done;

    logic [7:0]      cmd_mem  [FIFO_DEPTH];
    logic [31:0]     data_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            empty_q, full_q, lost_q, lost_d;
    logic [7:0]      out_cmd_q, out_cmd_d;
    logic [31:0]     out_data_q, out_data_d;
    logic            pop_ok, wr_en, drop;

    // Frame assembler and idle timeout
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cmd_d      = cmd_q;
        data_d     = data_q;
        to_d       = to_q;
        timeout_d  = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            S_CMD: begin
                if (byte_valid) begin
                    cmd_d   = byte_in;
                    idx_d   = 2'd0;
                    to_d    = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (byte_valid) begin
                    to_d                       = '0;
                    data_d[{idx_q, 3'b000} +: 8] = byte_in;
                    idx_d                      = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        frame_done = 1'b1;
                        state_d    = S_CMD;
                    end
                end else if (to_q == ToW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_CMD;
                    idx_d     = 2'd0;
                    to_d      = '0;
                end else begin
                    to_d = to_q + ToW'(1);
                end
            end
            default: state_d = S_CMD;
        endcase
    end

    // A full FIFO still accepts a write when a pop frees the head slot this cycle
    always_comb begin
        pop_ok     = rx_pop_packet && !empty_q;
        wr_en      = frame_done && (!full_q || rx_pop_packet);
        drop       = frame_done && full_q && !rx_pop_packet;
        wr_ptr_d   = wr_en  ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (wr_en && !pop_ok) begin
            count_d = count_q + CntW'(1);
        end else if (!wr_en && pop_ok) begin
            count_d = count_q - CntW'(1);
        end
        out_cmd_d  = out_cmd_q;
        out_data_d = out_data_q;
        lost_d     = lost_q;
        if (pop_ok) begin
            out_cmd_d  = cmd_mem[rd_ptr_q];
            out_data_d = data_mem[rd_ptr_q];
            lost_d     = 1'b0;
        end
        if (drop) begin
            lost_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_CMD;
            idx_q      <= 2'd0;
            cmd_q      <= 8'd0;
            data_q     <= 32'd0;
            to_q       <= '0;
            timeout_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            lost_q     <= 1'b0;
            out_cmd_q  <= 8'd0;
            out_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cmd_q      <= cmd_d;
            data_q     <= data_d;
            to_q       <= to_d;
            timeout_q  <= timeout_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (count_d == CntW'(FIFO_DEPTH));
            lost_q     <= lost_d;
            out_cmd_q  <= out_cmd_d;
            out_data_q <= out_data_d;
        end
    end

    // Storage needs no reset; the pointers define which slots are live
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            cmd_mem[wr_ptr_q]  <= cmd_q;
            data_mem[wr_ptr_q] <= data_d;
        end
    end

    assign rx_command    = out_cmd_q;
    assign rx_data       = out_data_q;
    assign rx_empty      = empty_q;
    assign rx_full       = full_q;
    assign rx_lost_data  = lost_q;
    assign frame_timeout = timeout_q;

endmodule

// File: doc/hedios_rx_deframer.md
HEDIOS_RX_DEFRAMER -- requirements
Module: hedios_rx_deframer

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, default 4, packet slots (power of 2, >=2); TIMEOUT_CYCLES, default 100000, idle cycles before a partial frame is discarded.
REQ-002 The ports SHALL be:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- byte_in  in  8  received serial byte.
- byte_valid  in  1  one-cycle strobe; byte_in is valid on this cycle.
- rx_pop_packet  in  1  consumer pop request.
- rx_command  out  8  command of the last popped packet.
- rx_data  out  32  data of the last popped packet.
- rx_empty  out  1  FIFO holds no packet.
- rx_full  out  1  FIFO holds FIFO_DEPTH packets.
- rx_lost_data  out  1  sticky flag: a complete packet was dropped.
- frame_timeout  out  1  one-cycle pulse: a partial frame was discarded.

Function
REQ-003 A frame SHALL be exactly 5 bytes: the command byte, then data bytes LSB first (data[7:0], [15:8], [23:16], [31:24]).
REQ-004 The assembler FSM SHALL have two states: S_CMD (waiting for the command byte) and S_DATA (byte index 0..3).
REQ-005 In S_CMD, byte_valid SHALL capture byte_in as the command, clear the byte index, and move to S_DATA.
REQ-006 In S_DATA, byte_valid SHALL place byte_in at data[8*idx +: 8] and increment idx; the byte with idx==3 SHALL complete the frame and return the FSM to S_CMD.
REQ-007 On the cycle a frame completes with rx_full low, or with rx_full high and rx_pop_packet high, the packet SHALL be written to the FIFO tail; rx_empty SHALL be low on the next cycle.
REQ-008 If a frame completes while rx_full is high and rx_pop_packet is low, the packet SHALL be dropped and rx_lost_data SHALL be set from the next cycle.
REQ-009 rx_lost_data SHALL remain set until reset or until a pop is accepted; if a pop is accepted in the same cycle as a drop, rx_lost_data SHALL be set.
REQ-010 A pop SHALL be accepted when rx_pop_packet is high and rx_empty is low; the head entry SHALL then be registered into rx_command/rx_data and be visible on the following cycle.
REQ-011 rx_command and rx_data SHALL hold their value until the next accepted pop.
REQ-012 A pop while empty SHALL be ignored: no output change and no pointer change.
REQ-013 A simultaneous write and pop SHALL leave the occupancy count unchanged; a write into an empty FIFO with a pop in the same cycle SHALL NOT bypass, so the pop is ignored.
REQ-014 rx_empty SHALL equal (count==0) and rx_full SHALL equal (count==FIFO_DEPTH), both registered; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-015 A cycle counter SHALL run only in S_DATA and clear on every byte_valid.
REQ-016 When the cycle counter reaches TIMEOUT_CYCLES-1 with no byte_valid, the FSM SHALL return to S_CMD, discard the partial frame, and pulse frame_timeout for one cycle.
REQ-017 byte_valid on the expiry cycle SHALL take priority over the timeout: the byte is accepted and no timeout occurs.
REQ-018 A partial frame SHALL never be written to the FIFO.

Reset
REQ-019 While rst is low at a clock edge, the block SHALL apply: FSM=S_CMD, idx=0, timeout counter=0, pointers/count=0, rx_empty=1, rx_full=0, rx_lost_data=0, frame_timeout=0, rx_command=0, rx_data=0.
REQ-020 A reset mid-frame or with the FIFO non-empty SHALL discard all stored and partial data; the first byte_valid after reset release SHALL be treated as a command byte.

Verification
REQ-021 Send bytes 02,05,00,00,00 -> rx_empty falls the cycle after the last byte; pop -> the next cycle shows rx_command=02, rx_data=00000005.
REQ-022 Send bytes 81,78,56,34,12 -> pop shows rx_command=81, rx_data=12345678.
REQ-023 Send 5 frames with FIFO_DEPTH=4 and no pops -> rx_full=1 after the 4th frame, the 5th is dropped, rx_lost_data=1; 4 pops return frames 1-4 in order; rx_lost_data clears on the first pop; rx_empty=1 after the 4th pop.
REQ-024 With TIMEOUT_CYCLES=16, send 01,AA then idle 16 cycles -> frame_timeout pulses once; then 04,00,00,00,00 -> the popped packet is command 04, data 00000000.
REQ-025 Full FIFO, then complete a frame on the same cycle as a pop -> no loss, count stays 4, rx_lost_data=0.
REQ-026 Assert rst low after 3 bytes of a frame -> all outputs at reset values; the next 5 bytes form a clean packet.
